// File: rtl/mem_arbiter.sv
// Two-master round-robin front end for the single memory-subsystem port.
// Carries one transaction at a time and aborts it with an error strobe if the memory hangs.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [2:0]  m0_funct3,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_valid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [2:0]  m1_funct3,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_valid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_funct3,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

  // Timeout fires on the edge where the counter steps onto TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t           r_state;
  logic             r_last;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr, r_wdata, r_m0_rdata, r_m1_rdata;
  logic [2:0]       r_funct3;
  logic             r_we, r_m0_valid, r_m1_valid, r_m0_err, r_m1_err;

  logic w_any, w_sel, w_grant;

  // Handshake: a requester holds req with stable fields until gnt; the fields are
  // captured on the gnt edge, and exactly one of valid or err answers it later.
  assign w_any   = m0_req | m1_req;
  assign w_sel   = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_grant = (r_state == IDLE) & w_any;
  assign m0_gnt  = w_grant & ~w_sel;
  assign m1_gnt  = w_grant & w_sel;
  assign mem_ce  = (r_state == ISSUE) & ~mem_busy;

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_funct3 = r_funct3;
  assign mem_we     = r_we;
  assign owner      = r_owner;
  assign m0_valid   = r_m0_valid;
  assign m1_valid   = r_m1_valid;
  assign m0_err     = r_m0_err;
  assign m1_err     = r_m1_err;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_we       <= 1'b0;
      r_m0_valid <= 1'b0;
      r_m1_valid <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_valid <= 1'b0;
      r_m1_valid <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_addr   <= w_sel ? m1_addr   : m0_addr;
            r_wdata  <= w_sel ? m1_wdata  : m0_wdata;
            r_funct3 <= w_sel ? m1_funct3 : m0_funct3;
            r_we     <= w_sel ? m1_we     : m0_we;
            r_owner  <= w_sel;
            r_last   <= w_sel;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_busy) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A completion on the timeout cycle still counts as a completion.
          if (mem_valid) begin
            if (r_owner) begin
              r_m1_valid <= 1'b1;
              r_m1_rdata <= mem_rdata;
            end else begin
              r_m0_valid <= 1'b1;
              r_m0_rdata <= mem_rdata;
            end
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_state  <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_m0_err <= ~r_owner;
            r_m1_err <= r_owner;
            r_state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-timed memory responses, per-cycle expected values.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;
  logic        m0_gnt, m0_valid, m0_err, m1_gnt, m1_valid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ce, mem_we, mem_busy, mem_valid, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rd [2];

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_funct3(m0_funct3), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_valid(m0_valid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_funct3(m1_funct3), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_valid(m1_valid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .owner(owner), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = '0; m0_funct3 = '0; m0_we = 1'b0; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_funct3 = '0; m1_we = 1'b0; m1_wdata = '0;
    mem_busy = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    next_cycle();
    reset = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'({m0_gnt, m1_gnt}), 32'd0);
    check({tag, "_valid"}, 32'({m0_valid, m1_valid}), 32'd0);
    check({tag, "_err"},   32'({m0_err, m1_err}), 32'd0);
    check({tag, "_rd0"},   m0_rdata, 32'd0);
    check({tag, "_rd1"},   m1_rdata, 32'd0);
    check({tag, "_ctl"},   32'({mem_ce, mem_we, mem_funct3, owner}), 32'd0);
    check({tag, "_addr"},  mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // scoreboard for a completion strobe: owner p gets data, the other stays quiet and keeps rdata
  task automatic check_done(input string tag, input bit p, input logic [31:0] data);
    check({tag, "_valid_own"}, 32'(p ? m1_valid : m0_valid), 32'd1);
    check({tag, "_valid_oth"}, 32'(p ? m0_valid : m1_valid), 32'd0);
    check({tag, "_rdata_own"}, p ? m1_rdata : m0_rdata, data);
    check({tag, "_rdata_oth"}, p ? m0_rdata : m1_rdata, exp_rd[~p]);
    exp_rd[p] = data;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    next_cycle();
    next_cycle();
    settle();
    check_all_zero("reset");

    // single m0 read, 3-cycle memory latency
    next_cycle();
    reset = 1'b1;
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_funct3 = 3'b010;
    settle();
    check("t1_gnt0_c0", 32'({m0_gnt, m1_gnt}), 32'b10);
    next_cycle();
    m0_req = 1'b0;
    settle();
    check("t1_ce_c1", 32'(mem_ce), 32'd1);
    check("t1_addr_c1", mem_addr, 32'h0000_0100);
    check("t1_state_c1", 32'(dbg_state), 32'd1);
    next_cycle();
    settle();
    check("t1_ce_c2", 32'(mem_ce), 32'd0);
    next_cycle();
    next_cycle();
    mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    check("t1_novalid_c4", 32'(m0_valid), 32'd0);
    next_cycle();
    mem_valid = 1'b0;
    settle();
    check_done("t1_c5", 1'b0, 32'hDEAD_BEEF);
    check("t1_state_c5", 32'(dbg_state), 32'd0);
    next_cycle();
    settle();
    check("t1_valid_c6", 32'({m0_valid, m1_valid}), 32'd0);

    // both requesting from reset, 1-cycle memory: grants alternate m0, m1, m0, m1
    do_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h0000_00A0;
    m1_req = 1'b1; m1_addr = 32'h0000_00B0;
    for (int k = 0; k < 4; k++) begin
      bit own;
      own = k[0];
      mem_valid = 1'b0;
      settle();
      if (k > 0) check_done($sformatf("t2_done%0d", k - 1), ~own, 32'h1000 + 32'(k - 1));
      check($sformatf("t2_gnt%0d", k), 32'({m0_gnt, m1_gnt}), own ? 32'b01 : 32'b10);
      next_cycle();
      settle();
      check($sformatf("t2_ce%0d", k), 32'(mem_ce), 32'd1);
      check($sformatf("t2_owner%0d", k), 32'(owner), 32'(own));
      check($sformatf("t2_addr%0d", k), mem_addr, own ? 32'h0000_00B0 : 32'h0000_00A0);
      next_cycle();
      mem_valid = 1'b1; mem_rdata = 32'h1000 + 32'(k);
      settle();
      check($sformatf("t2_wait%0d", k), 32'(dbg_state), 32'd2);
      next_cycle();
    end
    mem_valid = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    settle();
    check_done("t2_done3", 1'b1, 32'h1003);

    // m1 write, memory busy for 2 cycles on ISSUE entry
    next_cycle();
    m1_req = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_funct3 = 3'b010; m1_we = 1'b1;
    settle();
    check("t3_gnt1", 32'({m0_gnt, m1_gnt}), 32'b01);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      m1_req = 1'b0; mem_busy = 1'b1;
      settle();
      check($sformatf("t3_ce_busy%0d", c), 32'(mem_ce), 32'd0);
      check($sformatf("t3_state_busy%0d", c), 32'(dbg_state), 32'd1);
    end
    next_cycle();
    mem_busy = 1'b0;
    settle();
    check("t3_ce", 32'(mem_ce), 32'd1);
    check("t3_fields", 32'({mem_we, mem_funct3, owner}), 32'b1_010_1);
    check("t3_wdata", mem_wdata, 32'h1234_5678);
    next_cycle();
    mem_busy = 1'b1;
    settle();
    check("t3_hold_we", 32'({mem_ce, mem_we}), 32'b01);
    check("t3_hold_wdata", mem_wdata, 32'h1234_5678);
    next_cycle();
    mem_busy = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0;
    settle();
    check("t3_hold_addr", mem_addr, 32'h20);
    next_cycle();
    mem_valid = 1'b0;
    settle();
    check_done("t3_done", 1'b1, 32'h0);
    check("t3_idle_clear", 32'({mem_we, mem_funct3}), 32'd0);
    check("t3_idle_wdata", mem_wdata, 32'h1234_5678);

    // timeout: memory never completes, busy high for 20 cycles, m1 waiting behind
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h40; m0_we = 1'b0; m0_funct3 = 3'b010;
    settle();
    check("t4_gnt0", 32'({m0_gnt, m1_gnt}), 32'b10);
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0;
    settle();
    check("t4_ce", 32'(mem_ce), 32'd1);
    for (int c = 2; c <= 8; c++) begin
      next_cycle();
      mem_busy = 1'b1;
      settle();
      check($sformatf("t4_noerr_c%0d", c), 32'({m0_err, m1_gnt}), 32'd0);
      check($sformatf("t4_wait_c%0d", c), 32'(dbg_state), 32'd2);
    end
    next_cycle();
    settle();
    check("t4_err_c9", 32'({m0_err, m0_valid, m1_err}), 32'b100);
    check("t4_drain_c9", 32'(dbg_state), 32'd3);
    for (int c = 10; c <= 22; c++) begin
      next_cycle();
      mem_valid = (c == 11);
      mem_rdata = 32'h0000_0BAD;
      if (c == 22) mem_busy = 1'b0;
      settle();
      check($sformatf("t4_quiet_c%0d", c), 32'({m0_err, m0_valid, m1_valid, m1_gnt}), 32'd0);
    end
    check("t4_rd0_kept", m0_rdata, exp_rd[0]);
    next_cycle();
    settle();
    check("t4_gnt1_c23", 32'({m0_gnt, m1_gnt}), 32'b01);

    // reset while in WAIT drops the transaction
    do_reset();
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h300; m0_we = 1'b1; m0_funct3 = 3'b001; m0_wdata = 32'hA5A5_A5A5;
    next_cycle();
    m0_req = 1'b0;
    next_cycle();
    settle();
    check("t5_in_wait", 32'({dbg_state, mem_we}), 32'b10_1);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    settle();
    check_all_zero("t5_after_rst");
    next_cycle();
    mem_valid = 1'b1; mem_rdata = 32'h77;
    next_cycle();
    mem_valid = 1'b0;
    settle();
    check("t5_no_valid", 32'({m0_valid, m1_valid, m0_err}), 32'd0);
    check("t5_rd0", m0_rdata, 32'd0);

    // completion on the exact timeout cycle wins over the error
    next_cycle();
    m0_req = 1'b1; m0_addr = 32'h500; m0_we = 1'b0; m0_funct3 = 3'b010;
    settle();
    check("t6_gnt0", 32'({m0_gnt, m1_gnt}), 32'b10);
    next_cycle();
    m0_req = 1'b0;
    for (int c = 2; c <= 8; c++) next_cycle();
    mem_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    next_cycle();
    mem_valid = 1'b0;
    settle();
    check_done("t6_done", 1'b0, 32'hCAFE_F00D);
    check("t6_no_err", 32'({m0_err, m1_err}), 32'd0);
    check("t6_idle", 32'(dbg_state), 32'd0);
    next_cycle();
    settle();
    check("t6_quiet", 32'({m0_err, m0_valid}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory-subsystem port (ce/addr/funct3/memwrite/datain, busy/valid/dataout) between two requesters.
- Requester 0 is the CPU core; requester 1 is a secondary master (UART boot loader / DMA).
- Round-robin arbitration, one outstanding transaction at a time, with a per-transaction timeout so a hung peripheral cannot wedge either master.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles in WAIT before the transaction is aborted with an error (must be >= 2).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- m0_req  in  1  requester 0 request; held with fields stable until m0_gnt
- m0_addr  in  32  requester 0 byte address
- m0_funct3  in  3  requester 0 access size/sign (RISC-V load/store encoding)
- m0_we  in  1  requester 0 write enable
- m0_wdata  in  32  requester 0 write data
- m0_gnt  out  1  request accepted; fields latched this edge
- m0_valid  out  1  one-cycle completion strobe
- m0_rdata  out  32  read data, valid with m0_valid
- m0_err  out  1  one-cycle timeout strobe
- m1_*  same set as m0_*, for requester 1
- mem_ce  out  1  one-cycle start strobe to memory
- mem_addr  out  32  latched address
- mem_funct3  out  3  latched funct3
- mem_we  out  1  latched write enable
- mem_wdata  out  32  latched write data
- mem_busy  in  1  memory is processing
- mem_valid  in  1  memory completion strobe
- mem_rdata  in  32  memory read data
- owner  out  1  index of the requester owning the current transaction

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; last=1; counter=0.
  - All outputs 0: gnt, valid, err, rdata, mem_* and owner.
  - Any in-flight transaction is dropped without valid or err.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - Selection: if exactly one req is high, that requester is selected. If both are high, select the requester != last.
  - mX_gnt is combinational, asserted only for the selected requester, only in IDLE.
  - On the edge with gnt: latch addr/funct3/we/wdata into the mem_* registers, set owner and last to the selected requester, go to ISSUE.
  - A requester that keeps req high after gnt is posting a new request. It is arbitrated on the next return to IDLE.
- ISSUE:
  - If mem_busy==1: mem_ce=0, remain in ISSUE.
  - Otherwise: mem_ce=1 for exactly one cycle, counter cleared, go to WAIT.
- WAIT:
  - mem_* outputs are held stable; the counter increments each cycle.
  - On mem_valid: register mem_rdata into m[owner]_rdata and pulse m[owner]_valid on the next cycle, in which state is IDLE.
  - Otherwise, when counter reaches TIMEOUT_CYCLES-1: pulse m[owner]_err next cycle (valid stays 0), go to DRAIN.
  - If mem_valid and the timeout coincide, mem_valid wins.
- DRAIN: ignore mem_valid; go to IDLE once mem_busy==0.
- Latency:
  - gnt at edge N.
  - mem_ce at cycle N+1 (memory idle).
  - mem_valid at cycle M.
  - mX_valid at cycle M+1.
  - Next gnt possible at cycle M+1; back-to-back period is 2 cycles plus memory latency.
- Non-owner outputs:
  - valid/err never pulse for the non-owner.
  - rdata of the non-owner retains its last value.
- mem_we/mem_funct3 are cleared to 0 in IDLE; mem_addr and mem_wdata hold their last value.

Test Plan:
- Single m0 read, addr=0x0000_0100, memory returns 0xDEADBEEF after 3 cycles -> m0_gnt at cycle 0, mem_ce one cycle at cycle 1, m0_valid=1 with m0_rdata=0xDEADBEEF at cycle 5; m1_valid stays 0.
- m0_req and m1_req high together from reset, each held -> grants in order m0, m1, m0, m1. Each valid goes only to its owner; owner toggles per transaction.
- m1 write addr=0x20, wdata=0x12345678, funct3=010, with mem_busy=1 for 2 cycles at ISSUE entry -> mem_ce delayed 2 cycles; mem_we=1 and wdata stable until mem_valid.
- TIMEOUT_CYCLES=8, memory never asserts valid, busy stays high 20 cycles -> m0_err pulses 8 cycles after mem_ce and m0_valid stays 0. A late mem_valid in DRAIN is ignored. m1_req is granted only after busy falls.
- Reset asserted in WAIT -> next cycle all outputs 0 and state IDLE. A mem_valid arriving afterwards produces no valid pulse.
- mem_valid on the exact timeout cycle -> valid pulses, err stays 0, state returns to IDLE.
